cc_pipeline_sequencer: RTL and testbench

//  Multi-frame successor to the SPI->Trigger->CC->UART pipeline controller; sits in Primary, no datapath.
//  On an accepted trigger: freezes SPI capture, then runs NUM_FRAMES cross-correlation/TX rounds back to back.

---
 rtl/cc_pipeline_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_cc_pipeline_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// cc_pipeline_sequencer
//
// Purpose:
//   Control-only sequencer for the SPI -> Trigger -> CC -> UART pipeline.
//   An accepted trigger freezes SPI capture and then runs NUM_FRAMES
//   cross-correlation / UART transmit rounds back to back. After the last
//   round a programmable holdoff stops one ping from triggering twice.
//   Triggers that arrive while the block is not accepting are counted.
//
// Optional feature (macro CC_WATCHDOG_EN):
//   A watchdog bounds the wait for CC_Done. If it expires, the burst is
//   abandoned into HOLDOFF and the sticky cc_err flag is raised. With the
//   macro undefined, WAIT_CC waits forever and cc_err is tied to 0.
//
// Ports:
//   clk                 in   system clock
//   reset_b             in   synchronous active-low reset
//   arm                 in   allows trigger acceptance in IDLE
//   Trigger             in   trigger pulse/level
//   CC_Done             in   CC block finished current frame
//   Tx_Ready            in   UART accepted current result
//   cfg_holdoff         in   post-burst holdoff length in clk cycles
//   Trigger_Persistant  out  ring buffer freeze, TRIGGERED through TX_EN
//   Start_CC            out  one-cycle start pulse per frame
//   TX_en               out  UART send request for current frame
//   SPI_en              out  SPI capture enable
//   frame_idx           out  frame in progress
//   busy                out  sequencer not idle
//   missed_trig         out  saturating count of unaccepted triggers
//   cc_err              out  sticky CC watchdog error
// ---------------------------------------------------------------------------
module cc_pipeline_sequencer #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_W     = 2,
  parameter int HOLD_W      = 20,
  parameter int WDOG_CYCLES = 2000000,
  parameter int WDOG_W      = 21
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              arm,
  input  logic              Trigger,
  input  logic              CC_Done,
  input  logic              Tx_Ready,
  input  logic [HOLD_W-1:0] cfg_holdoff,
  output logic              Trigger_Persistant,
  output logic              Start_CC,
  output logic              TX_en,
  output logic              SPI_en,
  output logic [FRAME_W-1:0] frame_idx,
  output logic              busy,
  output logic [7:0]        missed_trig,
  output logic              cc_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIGGERED = 3'd1;
  localparam logic [2:0] S_WAIT_CC   = 3'd2;
  localparam logic [2:0] S_TX_EN     = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  logic [2:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         missed_q, missed_d;
  logic               accept;

`ifdef CC_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              cc_err_q, cc_err_d;
`endif

  // A trigger is only taken in IDLE while armed; anything else is a miss.
  assign accept = (state_q == S_IDLE) && arm;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    missed_d = missed_q;
`ifdef CC_WATCHDOG_EN
    wdog_d   = wdog_q;
    cc_err_d = cc_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Trigger && arm) begin
          state_d = S_TRIGGERED;
          frame_d = '0;
`ifdef CC_WATCHDOG_EN
          cc_err_d = 1'b0;
`endif
        end
      end
      S_TRIGGERED: begin
        state_d = S_WAIT_CC;
`ifdef CC_WATCHDOG_EN
        wdog_d = '0;
`endif
      end
      S_WAIT_CC: begin
        if (CC_Done) begin
          state_d = S_TX_EN;
`ifdef CC_WATCHDOG_EN
        end else if (wdog_q == WDOG_LAST) begin
          // CC block hung: abandon the burst but still honour the holdoff.
          state_d  = S_HOLDOFF;
          hold_d   = cfg_holdoff;
          cc_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      S_TX_EN: begin
        // Tx_Ready is only examined here, so TX_EN always lasts a cycle.
        if (Tx_Ready) begin
          if (frame_q == LAST_FRAME) begin
            state_d = S_HOLDOFF;
            hold_d  = cfg_holdoff;
          end else begin
            state_d = S_TRIGGERED;
            frame_d = frame_q + 1'b1;
          end
        end
      end
      S_HOLDOFF: begin
        // Leaving on zero means a holdoff of N gives N+1 HOLDOFF cycles.
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (Trigger && !accept && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end
  end

  // All state is reset synchronously; no pending TX survives a reset.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      hold_q   <= '0;
      missed_q <= '0;
`ifdef CC_WATCHDOG_EN
      wdog_q   <= '0;
      cc_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      missed_q <= missed_d;
`ifdef CC_WATCHDOG_EN
      wdog_q   <= wdog_d;
      cc_err_q <= cc_err_d;
`endif
    end
  end

  // Moore output decode; unused encodings fall into the IDLE values.
  always_comb begin
    Trigger_Persistant = 1'b0;
    Start_CC           = 1'b0;
    TX_en              = 1'b0;
    SPI_en             = 1'b1;
    busy               = 1'b0;
    case (state_q)
      S_TRIGGERED: begin
        Start_CC           = 1'b1;
        Trigger_Persistant = 1'b1;
        SPI_en             = 1'b0;
        busy               = 1'b1;
      end
      S_WAIT_CC: begin
        Trigger_Persistant = 1'b1;
        SPI_en             = 1'b0;
        busy               = 1'b1;
      end
      S_TX_EN: begin
        TX_en              = 1'b1;
        Trigger_Persistant = 1'b1;
        SPI_en             = 1'b0;
        busy               = 1'b1;
      end
      S_HOLDOFF: begin
        SPI_en = 1'b0;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_idx   = frame_q;
  assign missed_trig = missed_q;

`ifdef CC_WATCHDOG_EN
  assign cc_err = cc_err_q;
`else
  assign cc_err = 1'b0;
`endif

endmodule

// File: tb/tb_cc_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cc_pipeline_sequencer
//
// Directed bench for cc_pipeline_sequencer with NUM_FRAMES=4. Inputs are
// driven 1 ns after each rising edge and the Moore outputs are sampled at
// the same point. When CC_WATCHDOG_EN is defined the watchdog is shortened
// to 50 cycles and the watchdog scenario is exercised as well.
// ---------------------------------------------------------------------------
module tb_cc_pipeline_sequencer;

  localparam int HOLD_W = 20;
`ifdef CC_WATCHDOG_EN
  localparam int WD = 50;
`else
  localparam int WD = 2000000;
`endif

  logic              clk = 1'b0;
  logic              reset_b;
  logic              arm;
  logic              Trigger;
  logic              CC_Done;
  logic              Tx_Ready;
  logic [HOLD_W-1:0] cfg_holdoff;
  logic              Trigger_Persistant;
  logic              Start_CC;
  logic              TX_en;
  logic              SPI_en;
  logic [1:0]        frame_idx;
  logic              busy;
  logic [7:0]        missed_trig;
  logic              cc_err;

  int checks   = 0;
  int failures = 0;

  cc_pipeline_sequencer #(
    .NUM_FRAMES (4),
    .FRAME_W    (2),
    .HOLD_W     (HOLD_W),
    .WDOG_CYCLES(WD),
    .WDOG_W     (21)
  ) dut (
    .clk               (clk),
    .reset_b           (reset_b),
    .arm               (arm),
    .Trigger           (Trigger),
    .CC_Done           (CC_Done),
    .Tx_Ready          (Tx_Ready),
    .cfg_holdoff       (cfg_holdoff),
    .Trigger_Persistant(Trigger_Persistant),
    .Start_CC          (Start_CC),
    .TX_en             (TX_en),
    .SPI_en            (SPI_en),
    .frame_idx         (frame_idx),
    .busy              (busy),
    .missed_trig       (missed_trig),
    .cc_err            (cc_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case the DUT wedges somewhere unexpected.
  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_persist"}, Trigger_Persistant, 0);
    checkOutput({tag, "_start_cc"}, Start_CC, 0);
    checkOutput({tag, "_tx_en"}, TX_en, 0);
    checkOutput({tag, "_spi_en"}, SPI_en, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame"}, frame_idx, 0);
    checkOutput({tag, "_missed"}, missed_trig, 0);
    checkOutput({tag, "_cc_err"}, cc_err, 0);
  endtask

  // One full accepted burst starting from IDLE, checking every frame and
  // the holdoff length.
  task automatic applyStimulus(input int hold, input bit rdyHeld, input bit ccInTrig);
    int n;
    cfg_holdoff = HOLD_W'(hold);
    Tx_Ready    = rdyHeld;
    Trigger     = 1'b1;
    cyc();
    Trigger = 1'b0;
    for (int f = 0; f < 4; f++) begin
      checkOutput("trig_start_cc", Start_CC, 1);
      checkOutput("trig_frame", frame_idx, f);
      checkOutput("trig_spi_en", SPI_en, 0);
      checkOutput("trig_persist", Trigger_Persistant, 1);
      CC_Done = ccInTrig;
      cyc();
      CC_Done = 1'b0;
      checkOutput("wait_start_cc", Start_CC, 0);
      checkOutput("wait_tx_en", TX_en, 0);
      checkOutput("wait_persist", Trigger_Persistant, 1);
      CC_Done = 1'b1;
      cyc();
      CC_Done = 1'b0;
      checkOutput("tx_en", TX_en, 1);
      checkOutput("tx_frame", frame_idx, f);
      if (!rdyHeld) begin
        cyc();
        checkOutput("tx_en_waiting", TX_en, 1);
        Tx_Ready = 1'b1;
      end
      cyc();
      Tx_Ready = rdyHeld;
    end
    checkOutput("hold_persist", Trigger_Persistant, 0);
    checkOutput("hold_tx_en", TX_en, 0);
    checkOutput("hold_spi_en", SPI_en, 0);
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_frame", frame_idx, 3);
    n = 0;
    while (busy && n < hold + 10) begin
      n++;
      cyc();
    end
    checkOutput("holdoff_cycles", n, hold + 1);
    checkOutput("idle_spi_en", SPI_en, 1);
    checkOutput("idle_frame_held", frame_idx, 3);
    Tx_Ready = 1'b0;
  endtask

  // Drives any burst in progress to completion with cfg_holdoff=0.
  task automatic finishToIdle(input string tag);
    int n;
    cfg_holdoff = '0;
    Tx_Ready    = 1'b1;
    CC_Done     = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      n++;
      cyc();
    end
    CC_Done  = 1'b0;
    Tx_Ready = 1'b0;
    checkOutput(tag, busy, 0);
  endtask

  initial begin
    reset_b     = 1'b0;
    arm         = 1'b0;
    Trigger     = 1'b0;
    CC_Done     = 1'b0;
    Tx_Ready    = 1'b0;
    cfg_holdoff = '0;
    cyc();
    cyc();
    checkResetValues("reset");
    reset_b = 1'b1;
    arm     = 1'b1;
    cyc();

    $display("[TB] basic 4-frame burst, holdoff 3");
    applyStimulus(3, 1'b0, 1'b0);

    $display("[TB] holdoff 100 and holdoff 0");
    applyStimulus(100, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);

    $display("[TB] Tx_Ready held high, CC_Done in TRIGGERED");
    applyStimulus(0, 1'b1, 1'b1);
    checkOutput("no_miss_yet", missed_trig, 0);

    $display("[TB] missed trigger counting");
    Trigger = 1'b1;
    cyc();
    Trigger = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      Trigger = 1'b1;
      cyc();
      Trigger = 1'b0;
      checkOutput("miss_no_start_cc", Start_CC, 0);
      checkOutput("miss_count_step", missed_trig, i + 1);
      cyc();
    end
    finishToIdle("miss_burst_done");
    arm     = 1'b0;
    Trigger = 1'b1;
    cyc();
    Trigger = 1'b0;
    checkOutput("disarmed_not_busy", busy, 0);
    checkOutput("missed_six", missed_trig, 6);
    Trigger = 1'b1;
    repeat (249) cyc();
    checkOutput("missed_reach_255", missed_trig, 255);
    repeat (51) cyc();
    checkOutput("missed_saturated", missed_trig, 255);
    Trigger = 1'b0;
    arm     = 1'b1;
    cyc();

    $display("[TB] reset during WAIT_CC of frame 2");
    Tx_Ready = 1'b1;
    Trigger  = 1'b1;
    cyc();
    Trigger = 1'b0;
    cyc();
    CC_Done = 1'b1;
    cyc();
    CC_Done = 1'b0;
    cyc();
    cyc();
    CC_Done = 1'b1;
    cyc();
    CC_Done = 1'b0;
    cyc();
    cyc();
    Tx_Ready = 1'b0;
    checkOutput("pre_reset_frame", frame_idx, 2);
    checkOutput("pre_reset_persist", Trigger_Persistant, 1);
    checkOutput("pre_reset_tx_en", TX_en, 0);
    reset_b = 1'b0;
    cyc();
    reset_b = 1'b1;
    checkResetValues("midreset");
    Trigger = 1'b1;
    cyc();
    Trigger = 1'b0;
    checkOutput("restart_frame", frame_idx, 0);
    checkOutput("restart_start_cc", Start_CC, 1);
    finishToIdle("restart_done");

`ifdef CC_WATCHDOG_EN
    begin
      int n;
      $display("[TB] CC watchdog expiry");
      cfg_holdoff = '0;
      Trigger = 1'b1;
      cyc();
      Trigger = 1'b0;
      cyc();
      n = 0;
      while (Trigger_Persistant && n < 200) begin
        n++;
        cyc();
      end
      checkOutput("wdog_cycles", n, 50);
      checkOutput("wdog_cc_err", cc_err, 1);
      checkOutput("wdog_holdoff_busy", busy, 1);
      cyc();
      checkOutput("wdog_idle", busy, 0);
      checkOutput("wdog_err_sticky", cc_err, 1);
      Trigger = 1'b1;
      cyc();
      Trigger = 1'b0;
      checkOutput("wdog_err_cleared", cc_err, 0);
      finishToIdle("wdog_done");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
